// File: rtl/enc_pkg.sv
// Shared definitions for the instruction-memory XOR cipher (loader and fetch side).
// Holds the loader state encoding, key-index geometry and word size, plus a
// word-alignment helper.
package enc_pkg;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned WORD_BYTES  = 4;
   // Key ROM index is taken from address bits [KEY_IDX_LSB +: KEY_IDX_W]
   localparam int unsigned KEY_IDX_LSB = 4;
   localparam int unsigned KEY_IDX_W   = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_LDRAIN = 3'd2,
      ST_VERIFY = 3'd3,
      ST_VDRAIN = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   // Clear the byte-offset bits of an address
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return addr & ~ADDR_W'(WORD_BYTES - 1);
   endfunction

endpackage

// File: rtl/imem_encrypt_loader_if.sv
// Plaintext stream, key ROM port and instruction-memory port of the loader.
//   in_valid_i/in_data_i/in_ready_o : plaintext word stream
//   key_addr_o/key_data_i           : key ROM index and data (1-cycle latency)
//   imem_*                          : instruction-memory write/read port
// master = loader side, slave = stream source / memory / key ROM side.
interface imem_encrypt_loader_if;
   import enc_pkg::*;

   logic                 in_valid_i;
   logic [DATA_W-1:0]    in_data_i;
   logic                 in_ready_o;
   logic [KEY_IDX_W-1:0] key_addr_o;
   logic [DATA_W-1:0]    key_data_i;
   logic                 imem_we_o;
   logic                 imem_re_o;
   logic [ADDR_W-1:0]    imem_addr_o;
   logic [DATA_W-1:0]    imem_wdata_o;
   logic [DATA_W-1:0]    imem_rdata_i;

   modport master (
      input  in_valid_i, in_data_i, key_data_i, imem_rdata_i,
      output in_ready_o, key_addr_o, imem_we_o, imem_re_o, imem_addr_o, imem_wdata_o
   );

   modport slave (
      output in_valid_i, in_data_i, key_data_i, imem_rdata_i,
      input  in_ready_o, key_addr_o, imem_we_o, imem_re_o, imem_addr_o, imem_wdata_o
   );

endinterface

// File: rtl/enc_checksum.sv
// XOR accumulator used for the load-side and readback-side checksums.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr          : zero the accumulator (wins over en)
//   en           : fold din into the accumulator
//   din          : word to accumulate
//   sum          : registered running XOR
module enc_checksum
   import enc_pkg::*;
#(
   parameter int unsigned W = DATA_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] sum
);

   always_ff @(posedge clk_i) begin
      if (rst_i || clr) begin
         sum <= '0;
      end else if (en) begin
         sum <= sum ^ din;
      end
   end

endmodule

// File: rtl/imem_encrypt_loader.sv
// Encrypting program loader: writes plaintext ^ key[addr[7:4]] into instruction
// memory, optionally reads the image back and compares XOR checksums.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   start_i       : begin a load (IDLE only), with base_addr_i and n_words_i
//   bus           : plaintext stream, key ROM and instruction-memory port
//   busy_o        : not IDLE
//   done_o        : one-cycle end-of-load pulse
//   pass_o        : verify result, held until the next accepted start
module imem_encrypt_loader
   import enc_pkg::*;
#(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned VERIFY_EN = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_W-1:0]     base_addr_i,
   input  logic [CNT_W-1:0]      n_words_i,
   imem_encrypt_loader_if.master bus,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o
);

   state_e state_q, state_d;

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [CNT_W-1:0]  n_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] pt_q;
   logic              wr_pend_q;
   logic              rd_pend_q;
   logic              pass_q;

   logic              start_c;
   logic              ready_c;
   logic              accept_c;
   logic              read_c;
   logic              last_c;
   logic [DATA_W-1:0] rd_word_c;
   logic [DATA_W-1:0] sum_a;
   logic [DATA_W-1:0] sum_b;

   // Readback word decrypted with the key for the address read last cycle
   assign rd_word_c = bus.imem_rdata_i ^ bus.key_data_i;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-cycle control
   always_comb begin
      state_d  = state_q;
      start_c  = 1'b0;
      ready_c  = 1'b0;
      accept_c = 1'b0;
      read_c   = 1'b0;
      // Shared by LOAD (handshakes) and VERIFY (reads): this one is the n-th
      last_c   = (cnt_q + CNT_W'(1)) == n_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               start_c = 1'b1;
               state_d = (n_words_i == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            ready_c  = cnt_q < n_q;
            accept_c = ready_c & bus.in_valid_i;
            if (accept_c && last_c) begin
               state_d = ST_LDRAIN;
            end
         end
         ST_LDRAIN: begin
            state_d = (VERIFY_EN != 0) ? ST_VERIFY : ST_DONE;
         end
         ST_VERIFY: begin
            read_c = 1'b1;
            if (last_c) begin
               state_d = ST_VDRAIN;
            end
         end
         ST_VDRAIN: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Address/count/plaintext pipeline and verify result
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q    <= '0;
         base_q    <= '0;
         wr_addr_q <= '0;
         n_q       <= '0;
         cnt_q     <= '0;
         pt_q      <= '0;
         wr_pend_q <= 1'b0;
         rd_pend_q <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         wr_pend_q <= accept_c;
         rd_pend_q <= read_c;
         if (accept_c) begin
            pt_q      <= bus.in_data_i;
            wr_addr_q <= addr_q;
         end
         // Address wraps modulo 2^32; the key index follows the wrapped value
         if (accept_c || read_c) begin
            addr_q <= addr_q + ADDR_W'(WORD_BYTES);
            cnt_q  <= cnt_q + CNT_W'(1);
         end
         case (state_q)
            ST_IDLE: begin
               if (start_c) begin
                  base_q <= word_align(base_addr_i);
                  addr_q <= word_align(base_addr_i);
                  n_q    <= n_words_i;
                  cnt_q  <= '0;
                  // An empty load trivially passes
                  pass_q <= (n_words_i == '0);
               end
            end
            ST_LDRAIN: begin
               addr_q <= base_q;
               cnt_q  <= '0;
               if (VERIFY_EN == 0) begin
                  pass_q <= 1'b1;
               end
            end
            ST_VDRAIN: begin
               // Include the final read, which lands this cycle
               pass_q <= (sum_a == (sum_b ^ rd_word_c));
            end
            default: begin
            end
         endcase
      end
   end

   // Plaintext checksum
   enc_checksum #(.W(DATA_W)) u_sum_a (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (start_c),
      .en    (accept_c),
      .din   (bus.in_data_i),
      .sum   (sum_a)
   );

   // Decrypted readback checksum
   enc_checksum #(.W(DATA_W)) u_sum_b (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (start_c),
      .en    (rd_pend_q),
      .din   (rd_word_c),
      .sum   (sum_b)
   );

   // Key data arrives one cycle after key_addr, matching the write of a
   // word registered on the previous handshake and the read issued last cycle
   assign bus.in_ready_o   = ready_c;
   assign bus.key_addr_o   = addr_q[KEY_IDX_LSB +: KEY_IDX_W];
   assign bus.imem_we_o    = wr_pend_q;
   assign bus.imem_re_o    = read_c;
   assign bus.imem_addr_o  = wr_pend_q ? wr_addr_q : (read_c ? addr_q : '0);
   assign bus.imem_wdata_o = wr_pend_q ? (pt_q ^ bus.key_data_i) : '0;

   assign busy_o = (state_q != ST_IDLE);
   assign done_o = (state_q == ST_DONE);
   assign pass_o = pass_q;

endmodule
